mpsoc_cpu_oci_dct_ctrl: RTL and testbench

MPSOC_CPU_OCI_DCT_CTRL -- requirements
Module: mpsoc_cpu_oci_dct_ctrl

---
 rtl/mpsoc_cpu_oci_dct_ctrl.sv | 136 +++++++++++++
 tb/tb_mpsoc_cpu_oci_dct_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mpsoc_cpu_oci_dct_ctrl.sv
// Trace fragment packer: arbitrates itrace/dtrace symbols into 3-bit fragments,
// packs ten per 30-bit word and hands words downstream, with end-of-test flush.
module mpsoc_cpu_oci_dct_ctrl #(
    parameter int unsigned FRAGS = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 itr_req,
    input  logic [1:0]           itr_sym,
    output logic                 itr_gnt,
    input  logic                 dtr_req,
    input  logic [1:0]           dtr_sym,
    output logic                 dtr_gnt,
    input  logic                 flush,
    output logic [3*FRAGS-1:0]   dct_buffer,
    output logic [3:0]           dct_count,
    output logic                 word_valid,
    output logic [3*FRAGS-1:0]   word_data,
    output logic                 word_last,
    input  logic                 word_ready,
    output logic                 test_ending,
    output logic                 test_has_ended
);

    localparam int unsigned W  = 3 * FRAGS;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        PACK = 2'd0,
        OUT  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    buf_q, buf_d;
    logic [CW-1:0]   count_q, count_d;
    logic            last_q, last_d;
    logic            pend_q, pend_d;
    logic            ending_q, ending_d;
    logic            prio_itr_q, prio_itr_d;
    logic [2:0]      frag;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= PACK;
            buf_q      <= '0;
            count_q    <= '0;
            last_q     <= 1'b0;
            pend_q     <= 1'b0;
            ending_q   <= 1'b0;
            prio_itr_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            count_q    <= count_d;
            last_q     <= last_d;
            pend_q     <= pend_d;
            ending_q   <= ending_d;
            prio_itr_q <= prio_itr_d;
        end
    end

    // Arbitration, packing and word hand-off
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        count_d    = count_q;
        last_d     = last_q;
        pend_d     = pend_q;
        ending_d   = ending_q;
        prio_itr_d = prio_itr_q;
        itr_gnt    = 1'b0;
        dtr_gnt    = 1'b0;
        frag       = 3'b000;

        case (state_q)
            PACK: begin
                itr_gnt = itr_req && (!dtr_req || prio_itr_q);
                dtr_gnt = dtr_req && (!itr_req || !prio_itr_q);
                frag    = dtr_gnt ? {1'b1, dtr_sym} : {1'b0, itr_sym};
                if (itr_gnt || dtr_gnt) begin
                    for (int unsigned i = 0; i < FRAGS; i++) begin
                        if (count_q == CW'(i)) begin
                            buf_d[3*i +: 3] = frag;
                        end
                    end
                    count_d    = count_q + CW'(1);
                    prio_itr_d = dtr_gnt;
                end
                // A same-cycle fragment is already in buf_d, so it rides in the last word
                if (flush) begin
                    state_d  = OUT;
                    last_d   = 1'b1;
                    ending_d = 1'b1;
                end else if (count_d == CW'(FRAGS)) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (flush && !last_q) begin
                    pend_d   = 1'b1;
                    ending_d = 1'b1;
                end
                if (word_ready) begin
                    buf_d   = '0;
                    count_d = '0;
                    if (last_q) begin
                        state_d  = DONE;
                        ending_d = 1'b0;
                    end else if (pend_q || flush) begin
                        last_d = 1'b1;
                        pend_d = 1'b0;
                    end else begin
                        state_d = PACK;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = PACK;
            end
        endcase
    end

    assign dct_buffer     = buf_q;
    assign dct_count      = count_q;
    assign word_data      = buf_q;
    assign word_last      = last_q;
    assign word_valid     = (state_q == OUT);
    assign test_ending    = ending_q;
    assign test_has_ended = (state_q == DONE);

endmodule

// File: tb/tb_mpsoc_cpu_oci_dct_ctrl.sv
// Scoreboard bench for mpsoc_cpu_oci_dct_ctrl: expected words are queued by the
// stimulus thread and popped by a monitor on every downstream handshake.
module tb_mpsoc_cpu_oci_dct_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        itr_req, dtr_req, flush, word_ready;
    logic [1:0]  itr_sym, dtr_sym;
    logic        itr_gnt, dtr_gnt;
    logic [29:0] dct_buffer, word_data;
    logic [3:0]  dct_count;
    logic        word_valid, word_last, test_ending, test_has_ended;

    int n_vec = 0;
    int n_err = 0;

    logic [34:0] exp_q[$];
    logic [34:0] cur, held, exp_w;
    logic        hold_v = 1'b0;

    mpsoc_cpu_oci_dct_ctrl #(.FRAGS(10)) dut (
        .clk            (clk),
        .reset          (reset),
        .itr_req        (itr_req),
        .itr_sym        (itr_sym),
        .itr_gnt        (itr_gnt),
        .dtr_req        (dtr_req),
        .dtr_sym        (dtr_sym),
        .dtr_gnt        (dtr_gnt),
        .flush          (flush),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .word_valid     (word_valid),
        .word_data      (word_data),
        .word_last      (word_last),
        .word_ready     (word_ready),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Monitor: word contents on handshake, and stability while stalled
    always @(negedge clk) begin
        if (!reset && word_valid) begin
            cur = {word_data, dct_count, word_last};
            if (hold_v) check("hold_stable", 40'(cur), 40'(held));
            if (word_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got %h expected none", cur);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("word", 40'(cur), 40'(exp_w));
                end
                hold_v = 1'b0;
            end else begin
                held   = cur;
                hold_v = 1'b1;
            end
        end else begin
            hold_v = 1'b0;
        end
    end

    initial begin
        reset = 1'b1;
        itr_req = 1'b0; dtr_req = 1'b0; flush = 1'b0; word_ready = 1'b0;
        itr_sym = 2'b00; dtr_sym = 2'b00;
        #3;
        check("rst_buffer", 40'(dct_buffer), 40'd0);
        check("rst_count", 40'(dct_count), 40'd0);
        check("rst_valid", 40'(word_valid), 40'd0);
        check("rst_flags", 40'({word_last, test_ending, test_has_ended}), 40'd0);
        tick();
        reset = 1'b0;

        // Ten itrace fragments 3'b001
        word_ready = 1'b1;
        exp_q.push_back({30'h0924_9249, 4'd10, 1'b0});
        for (int i = 0; i < 10; i++) begin
            itr_req = 1'b1; itr_sym = 2'b01;
            #1;
            check("t1_gnt", 40'({itr_gnt, dtr_gnt}), 40'b10);
            tick();
        end
        itr_req = 1'b0;
        check("t1_valid", 40'(word_valid), 40'd1);
        tick();
        check("t1_back_pack", 40'({word_valid, dct_count}), 40'd0);

        // Round-robin with both requesters
        pulse_reset();
        exp_q.push_back({30'h33CF_3CF3, 4'd10, 1'b0});
        for (int i = 0; i < 10; i++) begin
            itr_req = 1'b1; itr_sym = 2'b11;
            dtr_req = 1'b1; dtr_sym = 2'b10;
            #1;
            check("t2_gnt", 40'({itr_gnt, dtr_gnt}), (i % 2 == 0) ? 40'b10 : 40'b01);
            tick();
        end
        itr_req = 1'b0; dtr_req = 1'b0;
        tick();

        // Partial word then flush
        pulse_reset();
        exp_q.push_back({30'h0000_0092, 4'd3, 1'b1});
        for (int i = 0; i < 3; i++) begin
            itr_req = 1'b1; itr_sym = 2'b10;
            tick();
        end
        itr_req = 1'b0; flush = 1'b1;
        #1;
        check("t3_ending_pre", 40'(test_ending), 40'd0);
        tick();
        flush = 1'b0;
        check("t3_out", 40'({word_valid, word_last, test_ending}), 40'b111);
        tick();
        check("t3_done", 40'({word_valid, test_ending, test_has_ended}), 40'b001);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        check("t3_done_hold", 40'({word_valid, dct_count, test_has_ended}), 40'b0_0000_1);

        // Full word stalled, flush during the stall
        pulse_reset();
        word_ready = 1'b0;
        exp_q.push_back({30'h1B6D_B6DB, 4'd10, 1'b0});
        exp_q.push_back({30'h0, 4'd0, 1'b1});
        for (int i = 0; i < 10; i++) begin
            itr_req = 1'b1; itr_sym = 2'b11;
            tick();
        end
        for (int h = 0; h < 5; h++) begin
            itr_req = 1'b1; dtr_req = 1'b1;
            flush = (h == 1);
            #1;
            check("t4_no_gnt", 40'({itr_gnt, dtr_gnt}), 40'b00);
            check("t4_stall", 40'({word_valid, dct_count}), 40'b1_1010);
            tick();
        end
        itr_req = 1'b0; dtr_req = 1'b0; flush = 1'b0;
        check("t4_ending", 40'(test_ending), 40'd1);
        word_ready = 1'b1;
        tick();
        check("t4_second", 40'({word_valid, word_last, dct_count}), 40'b11_0000);
        tick();
        check("t4_done", 40'({test_ending, test_has_ended}), 40'b01);

        // Flush with an empty buffer
        pulse_reset();
        exp_q.push_back({30'h0, 4'd0, 1'b1});
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_out", 40'({word_valid, word_last}), 40'b11);
        tick();
        check("t5_done", 40'(test_has_ended), 40'd1);

        // Flush on the acceptance that fills the word
        pulse_reset();
        exp_q.push_back({30'h2DB6_DB6D, 4'd10, 1'b1});
        for (int i = 0; i < 10; i++) begin
            dtr_req = 1'b1; dtr_sym = 2'b01;
            flush = (i == 9);
            tick();
        end
        dtr_req = 1'b0; flush = 1'b0;
        check("t6_out", 40'({word_valid, word_last, test_ending}), 40'b111);
        tick();
        check("t6_done", 40'({word_valid, test_has_ended}), 40'b01);

        // Asynchronous reset while a 7-fragment word is offered
        pulse_reset();
        word_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            itr_req = 1'b1; itr_sym = 2'b11;
            tick();
        end
        itr_req = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t7_out", 40'({word_valid, dct_count}), 40'b1_0111);
        #2;
        reset = 1'b1;
        #1;
        check("t7_async_valid", 40'({word_valid, word_last, test_ending, test_has_ended}), 40'd0);
        check("t7_async_data", 40'({dct_buffer, dct_count}), 40'd0);
        #1;
        reset = 1'b0;
        tick();
        word_ready = 1'b1;
        exp_q.push_back({30'h0924_9249, 4'd10, 1'b0});
        for (int i = 0; i < 10; i++) begin
            itr_req = 1'b1; itr_sym = 2'b01;
            #1;
            check("t7_gnt", 40'({itr_gnt, dtr_gnt}), 40'b10);
            tick();
        end
        itr_req = 1'b0;
        tick();
        check("t7_resume", 40'({word_valid, dct_count, test_has_ended}), 40'd0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("drain", 40'(exp_q.size()), 40'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
